uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 121 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// TX byte FIFO feeding an 8N1 UART serializer at CLK_DIV HCLK cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_busy,
  output logic       txd
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity;
  logic        tick;
  logic        txd_nxt;

  assign tx_fifo_full  = (count == FULL_CNT);
  assign tx_fifo_empty = (count == '0);
  assign push = tx_en && !tx_fifo_full;
  assign pop  = (state == IDLE) && !tx_fifo_empty;
  assign tick = (baud_cnt == DIV_LAST);

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    txd_nxt = 1'b1;
    case (state)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nxt = parity;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

  // txd/tx_busy are registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      txd     <= txd_nxt;
      tx_busy <= (state != IDLE);
      if (state != IDLE) baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
      case (state)
        IDLE: if (!tx_fifo_empty) begin
          shift    <= mem[rd_ptr];
          parity   <= ^mem[rd_ptr];
          baud_cnt <= '0;
          state    <= START;
        end
        START: if (tick) begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt == 3'd7) state <= PARITY;
`else
          if (bit_cnt == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) state <= STOP;
`endif
        STOP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: a queue-plus-frame-timer reference model compared every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [10:0] EXP55 = 11'b10010101010;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] EXP55 = 11'b01010101010;
`endif
  localparam int FL = NBITS * DIV;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_fifo_full, tx_fifo_empty, tx_busy, txd;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  logic prev_busy = 1'b0;

  uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .tx_en(tx_en), .tx_data(tx_data),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_busy(tx_busy), .txd(txd)
  );

  always #5 HCLK = ~HCLK;

  // Reference: byte queue plus "cycles since pop" timer for the frame on the wire.
  logic [7:0] q[$];
  bit         m_act = 0;
  int         m_fcnt = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_started = 0;
  bit         can_pop, can_push;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NBITS == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      q.delete();
      m_act = 0;
      m_fcnt = 0;
      m_started = 1;
    end else begin
      can_pop  = (q.size() > 0) && (!m_act || m_fcnt >= FL);
      can_push = tx_en && (q.size() < DEPTH);
      if (m_act) m_fcnt++;
      if (m_act && m_fcnt > FL) m_act = 0;
      if (can_pop) begin
        m_byte = q.pop_front();
        m_act = 1;
        m_fcnt = 0;
      end
      if (can_push) q.push_back(tx_data);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic etxd, ebusy;
    @(negedge HCLK);
    if (m_started) begin
      ebusy = m_act && (m_fcnt >= 1);
      etxd  = ebusy ? frame_bit(m_byte, (m_fcnt - 1) / DIV) : 1'b1;
      check("txd", 32'(txd), 32'(etxd));
      check("busy", 32'(tx_busy), 32'(ebusy));
      check("empty", 32'(tx_fifo_empty), 32'(q.size() == 0));
      check("full", 32'(tx_fifo_full), 32'(q.size() == DEPTH));
    end
    if (tx_busy === 1'b1 && prev_busy !== 1'b1) frames++;
    prev_busy = tx_busy;
  endtask

  task automatic wait_idle(input int limit);
    int quiet = 0;
    for (int i = 0; i < limit && quiet < 2; i++) begin
      tick();
      if (tx_fifo_empty === 1'b1 && tx_busy === 1'b0) quiet++;
      else quiet = 0;
    end
    check("wait_idle", 32'(quiet >= 2), 32'd1);
  endtask

  logic       s_txd  [0:159];
  logic       s_busy [0:159];
  logic [10:0] v;
  logic [7:0] b1, b2;
  logic       fullv [0:17];
  int         f0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    HRESETn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
      check("idle_empty", 32'(tx_fifo_empty), 32'd1);
      check("idle_full", 32'(tx_fifo_full), 32'd0);
    end

    // Single 0x55 frame, timing relative to push edge N
    f0 = frames;
    tx_en = 1'b1; tx_data = 8'h55;
    tick();
    tx_en = 1'b0;
    s_txd[0] = txd; s_busy[0] = tx_busy;
    for (int k = 1; k <= FL + 4; k++) begin
      tick();
      s_txd[k] = txd; s_busy[k] = tx_busy;
    end
    check("f55_busy_n1", 32'(s_busy[1]), 32'd0);
    check("f55_txd_n1", 32'(s_txd[1]), 32'd1);
    check("f55_busy_n2", 32'(s_busy[2]), 32'd1);
    for (int k = 2; k <= 5; k++) check("f55_start", 32'(s_txd[k]), 32'd0);
    v = '0;
    for (int i = 0; i < NBITS; i++) v[i] = s_txd[3 + 4*i];
    check("f55_bits", 32'(v), 32'(EXP55));
    check("f55_busy_last", 32'(s_busy[FL + 1]), 32'd1);
    check("f55_busy_fall", 32'(s_busy[FL + 2]), 32'd0);
    wait_idle(200);
    check("f55_frames", 32'(frames - f0), 32'd1);

    // Push 0xA3, then 0x0F on the cycle 0xA3 is popped
    f0 = frames;
    tx_en = 1'b1; tx_data = 8'hA3;
    tick();
    tx_data = 8'h0F;
    tick();
    tx_en = 1'b0;
    check("pp_count1_empty", 32'(tx_fifo_empty), 32'd0);
    check("pp_count1_full", 32'(tx_fifo_full), 32'd0);
    for (int k = 2; k <= 2*FL + 10; k++) begin
      tick();
      s_txd[k] = txd;
      if (k == 2) check("pp_hold_empty", 32'(tx_fifo_empty), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      b1[i] = s_txd[7 + 4*i];
      b2[i] = s_txd[FL + 8 + 4*i];
    end
    check("pp_byte1", 32'(b1), 32'hA3);
    check("pp_byte2", 32'(b2), 32'h0F);
    wait_idle(300);
    check("pp_frames", 32'(frames - f0), 32'd2);

    // Burst of 18 pushes into an idle serializer; the 18th is dropped
    f0 = frames;
    for (int i = 0; i < 18; i++) begin
      tx_en = 1'b1; tx_data = 8'(8'h41 + i);
      tick();
      fullv[i] = tx_fifo_full;
    end
    tx_en = 1'b0;
    check("burst_full16", 32'(fullv[15]), 32'd0);
    check("burst_full17", 32'(fullv[16]), 32'd1);
    check("burst_full18", 32'(fullv[17]), 32'd1);
    wait_idle(2000);
    check("burst_frames", 32'(frames - f0), 32'd17);

    // Hold tx_en while full; stop before the in-flight frame frees a slot
    f0 = frames;
    tx_en = 1'b1;
    for (int i = 1; i <= 41; i++) begin
      tx_data = 8'($urandom);
      tick();
      if (i == 16) check("hold_not_full", 32'(tx_fifo_full), 32'd0);
      if (i >= 17) check("hold_full", 32'(tx_fifo_full), 32'd1);
    end
    tx_en = 1'b0;
    wait_idle(2000);
    check("hold_frames", 32'(frames - f0), 32'd17);

    // Reset in the middle of data bit 3 with bytes queued
    tx_en = 1'b1;
    tx_data = 8'h00; tick();
    tx_data = 8'h12; tick();
    tx_data = 8'h34; tick();
    tx_en = 1'b0;
    repeat (15) tick();
    check("rst_pre_busy", 32'(tx_busy), 32'd1);
    check("rst_pre_txd", 32'(txd), 32'd0);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_empty", 32'(tx_fifo_empty), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_full", 32'(tx_fifo_full), 32'd0);
    f0 = frames;
    repeat (60) tick();
    check("rst_no_frames", 32'(frames - f0), 32'd0);

    // Random traffic, sparse then dense
    for (int i = 0; i < 400; i++) begin
      tx_en = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 200; i++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      tx_data = 8'($urandom);
      tick();
    end
    tx_en = 1'b0;
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
